// File: rtl/subbytes_shiftrows_seq.sv
// Byte-serial AES SubBytes+ShiftRows stage.
// A 128-bit state is accepted, its 16 bytes are streamed through a 2-stage
// pipelined S-box one per cycle, and each substituted byte is dropped into
// its ShiftRows position in a result register. A tag pipe runs alongside the
// S-box so that only bytes belonging to the current block are written.

// Pipelined AES S-box: stage 1 computes the GF(2^8) inverse, stage 2 the affine map.
module sbox (
  input  logic       clk,
  input  logic [7:0] din,
  output logic [7:0] dout
);

  logic [7:0] inv_q;

  // Multiplication in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse as x^254 = x^2 * x^4 * ... * x^128; zero maps to zero.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = gf_mul(x, x);
    acc = sq;
    for (int i = 0; i < 6; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  // Affine transform of the S-box: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // Two register stages; no reset, stale contents are masked by the caller's tags.
  always_ff @(posedge clk) begin
    inv_q <= gf_inv(din);
    dout  <= affine(inv_q);
  end

endmodule

// Sequencer around the S-box: handshake, byte feed, drain and result collection.
module subbytes_shiftrows_seq #(
  parameter int SBOX_LAT        = 2,
  parameter bit APPLY_SHIFTROWS = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  state_t       state;
  state_t       state_next;
  logic [3:0]   cnt;
  logic [3:0]   drain_cnt;
  logic [127:0] hold;
  logic [127:0] result;
  logic [7:0]   sbox_in;
  logic [7:0]   sbox_out;
  logic         tag_valid [SBOX_LAT];
  logic [3:0]   tag_idx   [SBOX_LAT];
  logic [3:0]   head_idx;
  logic [1:0]   head_row;
  logic [1:0]   head_col;
  logic [1:0]   dst_col;
  logic [3:0]   wr_pos;

  assign in_ready  = (state == IDLE) && !rst;
  assign out_state = result;

  // The hold register shifts left each FEED cycle, so the top byte is always byte[cnt].
  assign sbox_in = hold[127:120];

  sbox sbox_inst (
    .clk  (clk),
    .din  (sbox_in),
    .dout (sbox_out)
  );

  // Next-state decode of the block sequencer.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = FEED;
      FEED:    if (cnt == 4'd15) state_next = DRAIN;
      DRAIN:   if (drain_cnt == 4'(SBOX_LAT - 1)) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register; reset aborts whatever block is in progress.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Feed counter selects the byte index tagged alongside the S-box input.
  always_ff @(posedge clk) begin
    if (rst)                          cnt <= 4'd0;
    else if (state == IDLE)           cnt <= 4'd0;
    else if (state == FEED && cnt != 4'd15) cnt <= cnt + 4'd1;
  end

  // Drain counter waits out the S-box latency after the last byte is fed.
  always_ff @(posedge clk) begin
    if (rst)                 drain_cnt <= 4'd0;
    else if (state == DRAIN) drain_cnt <= drain_cnt + 4'd1;
    else                     drain_cnt <= 4'd0;
  end

  // Capture the input block on handshake, then shift one byte out per FEED cycle.
  always_ff @(posedge clk) begin
    if (rst)                            hold <= '0;
    else if (state == IDLE && in_valid) hold <= in_state;
    else if (state == FEED)             hold <= {hold[119:0], 8'h00};
  end

  // Output valid follows entry into DONE and drops on the output handshake.
  always_ff @(posedge clk) begin
    if (rst) out_valid <= 1'b0;
    else     out_valid <= (state_next == DONE);
  end

  // Tag pipe mirrors the S-box latency; only FEED cycles push a valid tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SBOX_LAT; i++) begin
        tag_valid[i] <= 1'b0;
        tag_idx[i]   <= 4'd0;
      end
    end else begin
      tag_valid[0] <= (state == FEED);
      tag_idx[0]   <= cnt;
      for (int i = 1; i < SBOX_LAT; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_idx[i]   <= tag_idx[i-1];
      end
    end
  end

  // Destination position: byte at (row r, column c) moves to column (c - r) mod 4.
  always_comb begin
    head_idx = tag_idx[SBOX_LAT-1];
    head_row = head_idx[1:0];
    head_col = head_idx[3:2];
    dst_col  = head_col - head_row;
    wr_pos   = APPLY_SHIFTROWS ? {dst_col, head_row} : head_idx;
  end

  // Collect each substituted byte as its tag reaches the head of the pipe.
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
    end else begin
      for (int k = 0; k < 16; k++) begin
        if (tag_valid[SBOX_LAT-1] && wr_pos == 4'(k)) result[127-8*k -: 8] <= sbox_out;
      end
    end
  end

endmodule
